// File: rtl/mem_arbiter.sv
// Byte-wide memory/IO bus arbiter between instruction fetch and the load/store buffer.
// Splits 1/2/4-byte accesses into single-byte bus cycles and assembles little-endian results.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LS_STRICT  = 0
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic                  flush_in,
  input  logic                  if_req_in,
  input  logic [ADDR_WIDTH-1:0] if_addr_in,
  output logic                  if_done_out,
  output logic [31:0]           if_data_out,
  input  logic                  ls_req_in,
  input  logic                  ls_we_in,
  input  logic [1:0]            ls_size_in,
  input  logic [ADDR_WIDTH-1:0] ls_addr_in,
  input  logic [31:0]           ls_wdata_in,
  output logic                  ls_done_out,
  output logic [31:0]           ls_rdata_out,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, IO_WAIT} state_t;

  state_t                state, state_nxt;
  logic [2:0]            cnt, cnt_nxt;
  logic [2:0]            nbytes, nbytes_nxt;
  logic                  who_ls, who_ls_nxt;
  logic                  is_io, is_io_nxt;
  logic                  prio_ls, prio_ls_nxt;
  logic [ADDR_WIDTH-1:0] base, base_nxt;
  logic [31:0]           wbuf, wbuf_nxt;
  logic [31:0]           rbuf, rbuf_nxt;

  logic [ADDR_WIDTH-1:0] mem_a_nxt;
  logic [7:0]            mem_dout_nxt;
  logic                  mem_wr_nxt;
  logic                  if_done_nxt, ls_done_nxt;
  logic [31:0]           if_data_nxt, ls_rdata_nxt;

  logic                  if_ok, ls_ok, grant_ls, grant_if;
  logic [2:0]            k;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [2:0]            req_n;
  logic                  req_we;
  logic                  req_io;

  function automatic logic [2:0] size_to_n(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic addr_is_io(input logic [ADDR_WIDTH-1:0] a);
    return a[17:16] == 2'b11;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] offset_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [2:0] idx);
    return a + ADDR_WIDTH'(idx);
  endfunction

  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [2:0] idx);
    case (idx)
      3'd0:    return w[7:0];
      3'd1:    return w[15:8];
      3'd2:    return w[23:16];
      3'd3:    return w[31:24];
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [2:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (idx)
      3'd0:    r[7:0]   = b;
      3'd1:    r[15:8]  = b;
      3'd2:    r[23:16] = b;
      3'd3:    r[31:24] = b;
      default: r = w;
    endcase
    return r;
  endfunction

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    nbytes_nxt   = nbytes;
    who_ls_nxt   = who_ls;
    is_io_nxt    = is_io;
    prio_ls_nxt  = prio_ls;
    base_nxt     = base;
    wbuf_nxt     = wbuf;
    rbuf_nxt     = rbuf;
    mem_a_nxt    = '0;
    mem_dout_nxt = '0;
    mem_wr_nxt   = 1'b0;
    if_done_nxt  = 1'b0;
    ls_done_nxt  = 1'b0;
    if_data_nxt  = if_data_out;
    ls_rdata_nxt = ls_rdata_out;
    // a requester whose done is showing this cycle sits out one arbitration round
    if_ok        = if_req_in && !if_done_out;
    ls_ok        = ls_req_in && !ls_done_out;
    grant_ls     = 1'b0;
    grant_if     = 1'b0;
    k            = cnt + 3'd1;
    req_addr     = if_addr_in;
    req_n        = 3'd4;
    req_we       = 1'b0;
    req_io       = 1'b0;

    case (state)
      IDLE: begin
        if (!flush_in) begin
          if (ls_ok && (LS_STRICT != 0 || !if_ok || prio_ls)) grant_ls = 1'b1;
          else if (if_ok)                                     grant_if = 1'b1;
        end
        if (grant_ls) begin
          req_addr = ls_addr_in;
          req_n    = size_to_n(ls_size_in);
          req_we   = ls_we_in;
        end
        if (grant_ls || grant_if) begin
          req_io      = addr_is_io(req_addr);
          base_nxt    = req_addr;
          wbuf_nxt    = ls_wdata_in;
          nbytes_nxt  = req_n;
          who_ls_nxt  = grant_ls;
          is_io_nxt   = req_io;
          prio_ls_nxt = grant_if;
          rbuf_nxt    = '0;
          cnt_nxt     = 3'd0;
          if (!req_we) begin
            state_nxt = READ;
            mem_a_nxt = req_addr;
          end else if (req_io && io_buffer_full) begin
            state_nxt = IO_WAIT;
          end else begin
            state_nxt    = WRITE;
            mem_a_nxt    = req_addr;
            mem_dout_nxt = ls_wdata_in[7:0];
            mem_wr_nxt   = 1'b1;
            cnt_nxt      = 3'd1;
          end
        end
      end

      READ: begin
        // cnt holds (edges since acceptance - 1); byte k-2 arrives on mem_din at edge k
        if (flush_in && !(who_ls && is_io)) begin
          state_nxt = IDLE;
          cnt_nxt   = 3'd0;
        end else begin
          if (k < nbytes) mem_a_nxt = offset_addr(base, k);
          if (k >= 3'd2)  rbuf_nxt  = put_byte(rbuf, k - 3'd2, mem_din);
          if (k == nbytes + 3'd1) begin
            state_nxt = IDLE;
            cnt_nxt   = 3'd0;
            if (who_ls) begin
              ls_done_nxt  = 1'b1;
              ls_rdata_nxt = rbuf_nxt;
            end else begin
              if_done_nxt  = 1'b1;
              if_data_nxt  = rbuf_nxt;
            end
          end else begin
            cnt_nxt = k;
          end
        end
      end

      WRITE: begin
        if (cnt == nbytes) begin
          ls_done_nxt = 1'b1;
          state_nxt   = IDLE;
          cnt_nxt     = 3'd0;
        end else if (is_io && io_buffer_full) begin
          state_nxt = IO_WAIT;
        end else begin
          mem_a_nxt    = offset_addr(base, cnt);
          mem_dout_nxt = pick_byte(wbuf, cnt);
          mem_wr_nxt   = 1'b1;
          cnt_nxt      = k;
        end
      end

      IO_WAIT: begin
        if (!io_buffer_full) begin
          state_nxt    = WRITE;
          mem_a_nxt    = offset_addr(base, cnt);
          mem_dout_nxt = pick_byte(wbuf, cnt);
          mem_wr_nxt   = 1'b1;
          cnt_nxt      = k;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state        <= IDLE;
      cnt          <= 3'd0;
      nbytes       <= 3'd0;
      who_ls       <= 1'b0;
      is_io        <= 1'b0;
      prio_ls      <= 1'b1;
      mem_a        <= '0;
      mem_dout     <= '0;
      mem_wr       <= 1'b0;
      if_done_out  <= 1'b0;
      ls_done_out  <= 1'b0;
      if_data_out  <= '0;
      ls_rdata_out <= '0;
    end else if (rdy_in) begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      nbytes       <= nbytes_nxt;
      who_ls       <= who_ls_nxt;
      is_io        <= is_io_nxt;
      prio_ls      <= prio_ls_nxt;
      mem_a        <= mem_a_nxt;
      mem_dout     <= mem_dout_nxt;
      mem_wr       <= mem_wr_nxt;
      if_done_out  <= if_done_nxt;
      ls_done_out  <= ls_done_nxt;
      if_data_out  <= if_data_nxt;
      ls_rdata_out <= ls_rdata_nxt;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      base <= base_nxt;
      wbuf <= wbuf_nxt;
      rbuf <= rbuf_nxt;
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Owns the CPU's single byte-wide memory/IO bus (mem_din/mem_dout/mem_a/mem_wr).
- Shares the bus between two requesters: instruction fetch (IF) and the load/store buffer (LS).
- Serialises each 1/2/4-byte access into per-byte bus cycles and assembles little-endian results.
- Throttles UART writes on io_buffer_full and aborts speculative reads on flush.

Parameters:
ADDR_WIDTH, 32, width of request addresses and mem_a
LS_STRICT, 0, 0 = alternate grants when both requesters pend; 1 = LS always wins

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  asynchronous active-low reset
rdy_in  input  1  global ready; low freezes the block
flush_in  input  1  pipeline flush (mispredict)
if_req_in  input  1  IF request; held high until if_done_out
if_addr_in  input  ADDR_WIDTH  IF address; always a 4-byte read
if_done_out  output  1  one-cycle pulse; if_data_out valid
if_data_out  output  32  fetched word
ls_req_in  input  1  LS request; held until ls_done_out
ls_we_in  input  1  1 = store, 0 = load
ls_size_in  input  2  00 byte, 01 half, 10 word, 11 treated as word
ls_addr_in  input  ADDR_WIDTH  LS address
ls_wdata_in  input  32  store data; low bytes used
ls_done_out  output  1  one-cycle completion pulse
ls_rdata_out  output  32  load result, zero-extended; sign extension is done by LS
mem_din  input  8  read byte; valid the cycle after its address
mem_dout  output  8  write byte
mem_a  output  ADDR_WIDTH  byte address
mem_wr  output  1  1 = write
io_buffer_full  input  1  UART TX buffer full

Behaviour:
- Reset (async, rst_n_in low): state IDLE; all outputs 0; grant pointer = LS. Reset mid-access abandons it; no done is issued.
- rdy_in low: all state, counters and outputs hold; mem_din is not sampled.
- States: IDLE, READ, WRITE, IO_WAIT. All outputs are registered.
- Arbitration (IDLE only):
  - LS_STRICT=1: LS wins whenever it requests.
  - LS_STRICT=0: if both request, grant the one not granted last.
  - A requester whose done_out is high in the current cycle is ignored that cycle (one-cycle turnaround).
- Byte count and addressing:
  - N = 4 for IF; N = 1/2/4 for LS.
  - Byte i uses address A+i with modulo-2^ADDR_WIDTH wrap.
  - No alignment check.
- Read, accepted at edge E0:
  - mem_a = A+i and mem_wr = 0 during the cycle after E_i, for i = 0..N-1.
  - Byte i is sampled from mem_din at E_{i+2} into data bits [8i+7:8i].
  - done is high for exactly the cycle after E_{N+1}. For a word fetch that is the 5th cycle after acceptance.
  - Data output holds until the next completion; unused high bytes are 0.
- Write, accepted at E0:
  - mem_a = A+i, mem_dout = wdata[8i+7:8i], mem_wr = 1 during the cycle after E_i.
  - ls_done_out is high in the cycle after E_N, with mem_wr = 0.
- IO address: A[17:16] == 2'b11.
  - Before issuing any IO write byte: if io_buffer_full is high, go to IO_WAIT with mem_wr = 0, mem_a = 0.
  - Issue the byte at the first edge where io_buffer_full is low.
- Idle bus: mem_a = 0, mem_wr = 0, mem_dout = 0 whenever no byte is being issued.
- flush_in high at an edge:
  - Aborts an in-flight IF read or a non-IO LS load: state goes to IDLE, bus goes idle, no done pulse.
  - LS stores and IO loads are committed operations; they always complete and report done.
  - A done that would assert at the flush edge is suppressed only for aborted operations.
- Simultaneous flush and new request in IDLE: flush wins; nothing is accepted that edge.

Test Plan:
- Word fetch, IF req 0x100, mem[0x100..0x103] = 13,05,00,00 -> mem_a = 0x100..0x103 on consecutive cycles; if_data_out = 0x00000513; if_done_out pulses once, 5 cycles after acceptance.
- LS half load 0x2001, bytes FF,80 -> ls_rdata_out = 0x000080FF; done 3 cycles after acceptance; byte store 0x41 to 0x1000 -> single mem_wr = 1 cycle with mem_dout = 0x41, done next cycle.
- Store 0x41 to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr stays 0 for 3 cycles, then exactly one write cycle with mem_a = 0x30000.
- IF and LS both requesting continuously, LS_STRICT=0 -> grants LS, IF, LS, IF…; no gap beyond the one-cycle turnaround.
- flush_in asserted 2 cycles into an IF fetch -> bus idle next cycle, no if_done_out; the same flush during a word store to 0x3000 -> all 4 bytes written, ls_done_out asserted.
- rdy_in low 4 cycles mid-load -> mem_a and counters frozen, result unchanged. rst_n_in low mid-store -> mem_wr = 0 immediately (async), no done.
